// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment codes are active-low {dp,g,f,e,d,c,b,a} with the dp bit off.
package seg7_scan_display_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // All digit selects released (active-low).
  localparam logic [5:0] SEL_OFF   = 6'h3F;

endpackage

// File: rtl/seg7_scan_display_bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment pattern {g..a}.
// Nibbles above 9 are not BCD and render as a dash so bad data is visible.
module bcd_to_seg7
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] code
);

  // Decode one nibble; anything outside 0..9 shows the dash.
  always_comb begin
    code = SEG_DASH[6:0];
    case (bcd)
      4'd0:    code = SEG_0[6:0];
      4'd1:    code = SEG_1[6:0];
      4'd2:    code = SEG_2[6:0];
      4'd3:    code = SEG_3[6:0];
      4'd4:    code = SEG_4[6:0];
      4'd5:    code = SEG_5[6:0];
      4'd6:    code = SEG_6[6:0];
      4'd7:    code = SEG_7[6:0];
      4'd8:    code = SEG_8[6:0];
      4'd9:    code = SEG_9[6:0];
      default: code = SEG_DASH[6:0];
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Six-digit multiplexed common-anode display driver.
// Scans digits 0..5 with a blank window at the start of every slot, latches
// the input once per frame so a display never mixes two values, blanks
// leading zeros and drives registered active-low seg/sel pins.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int         DIGIT_CYC = 50000,
  parameter int         BLANK_CYC = 500,
  parameter logic [5:0] DP_MASK   = 6'b010100,
  parameter int         LZ_BLANK  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] din,
  output logic [7:0]  seg,
  output logic [5:0]  sel
);

  localparam int            CW       = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYC - 1);
  localparam logic [2:0]    IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [23:0]   frame;

  logic          frame_start;
  logic          in_blank;
  logic [23:0]   frame_view;
  logic [5:0]    zero_run;
  logic [3:0]    nib;
  logic          lz;
  logic          dp;
  logic [6:0]    code;
  logic [7:0]    seg_next;
  logic [5:0]    sel_next;

  // Frame boundary detection; the value being latched this cycle is what the
  // display uses, so a zero-length blank window still shows the new frame.
  always_comb begin
    frame_start = en && (cnt == {CW{1'b0}}) && (idx == 3'd0);
    in_blank    = (int'(cnt) < BLANK_CYC);
    if (frame_start) begin
      frame_view = din;
    end else begin
      frame_view = frame;
    end
  end

  // Leading-zero run from the top digit down; digit 0 always shows.
  always_comb begin
    zero_run = 6'b000000;
    if (LZ_BLANK != 0) begin
      zero_run[NUM_DIGITS-1] = (frame_view[23:20] == 4'h0);
      for (int i = NUM_DIGITS - 2; i >= 1; i--) begin
        zero_run[i] = zero_run[i+1] && (frame_view[4*i +: 4] == 4'h0);
      end
    end else begin
      zero_run = 6'b000000;
    end
  end

  // Select the nibble, blanking flag and decimal point for the current slot.
  always_comb begin
    nib = 4'h0;
    lz  = 1'b0;
    dp  = 1'b0;
    case (idx)
      3'd0: begin nib = frame_view[3:0];   lz = zero_run[0]; dp = DP_MASK[0]; end
      3'd1: begin nib = frame_view[7:4];   lz = zero_run[1]; dp = DP_MASK[1]; end
      3'd2: begin nib = frame_view[11:8];  lz = zero_run[2]; dp = DP_MASK[2]; end
      3'd3: begin nib = frame_view[15:12]; lz = zero_run[3]; dp = DP_MASK[3]; end
      3'd4: begin nib = frame_view[19:16]; lz = zero_run[4]; dp = DP_MASK[4]; end
      3'd5: begin nib = frame_view[23:20]; lz = zero_run[5]; dp = DP_MASK[5]; end
      default: begin nib = 4'h0; lz = 1'b0; dp = 1'b0; end
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd  (nib),
    .code (code)
  );

  // Next pin values: dark when disabled or in the anti-ghost window.
  always_comb begin
    seg_next = SEG_BLANK;
    sel_next = SEL_OFF;
    if (!en || in_blank) begin
      seg_next = SEG_BLANK;
      sel_next = SEL_OFF;
    end else begin
      sel_next = ~(6'b000001 << idx);
      if (lz) begin
        seg_next = {~dp, SEG_BLANK[6:0]};
      end else begin
        seg_next = {~dp, code};
      end
    end
  end

  // Slot counter and digit index; both freeze while the display is disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= {CW{1'b0}};
      idx <= 3'd0;
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        cnt <= {CW{1'b0}};
        if (idx == IDX_LAST) begin
          idx <= 3'd0;
        end else begin
          idx <= idx + 3'd1;
        end
      end else begin
        cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Capture the six digits once per frame to avoid tearing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame <= 24'h000000;
    end else if (frame_start) begin
      frame <= din;
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= SEG_BLANK;
      sel <= SEL_OFF;
    end else begin
      seg <= seg_next;
      sel <= sel_next;
    end
  end

endmodule
